// File: rtl/calyx_sdiv_pkg.sv
// Shared types and helpers for the multi-cycle signed divider.
// Contents:
//   sdiv_state_e : divider FSM states
//   mag_t        : widest supported magnitude container (MAX_W+1 bits)
//   twos_mag()   : two's-complement magnitude of a sign-extended value; callers
//                  narrow the result with a (width+1)'() or width'() cast
package calyx_sdiv_pkg;

    // Widest operand the divider is built for.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } sdiv_state_e;

    typedef logic [MAX_W:0] mag_t;

    // Magnitude of a sign-extended value. One spare bit keeps |MIN| exact.
    function automatic mag_t twos_mag(input mag_t val);
        return val[MAX_W] ? (~val + mag_t'(1)) : val;
    endfunction

endpackage

// File: rtl/std_udiv_step.sv
// One restoring-division iteration on unsigned magnitudes (combinational).
// Ports:
//   rem_i : partial remainder before this step (always below the divisor)
//   msb_i : next dividend bit shifted into the partial remainder
//   div_i : divisor magnitude, width+1 bits so |MIN| fits
//   rem_o : partial remainder after this step
//   q_o   : quotient bit produced by this step
module std_udiv_step #(
    parameter int unsigned width = 32
) (
    input  logic [width-1:0] rem_i,
    input  logic             msb_i,
    input  logic [width:0]   div_i,
    output logic [width-1:0] rem_o,
    output logic             q_o
);

    logic [width:0] shifted;
    logic [width:0] diff;

    // Shifted remainder stays below 2^width, so bit [width] of the
    // width+1-bit difference is a reliable borrow/sign indicator.
    assign shifted = {rem_i, msb_i};
    assign diff    = shifted - div_i;
    assign q_o     = ~diff[width];
    assign rem_o   = q_o ? diff[width-1:0] : shifted[width-1:0];

endmodule

// File: rtl/std_sdiv_pipe.sv
// Multi-cycle signed divider with a go/done latency-insensitive handshake.
// Restoring division on operand magnitudes (one quotient bit per cycle)
// followed by a sign fix-up; truncating quotient/remainder semantics.
// Parameter:
//   width          : operand/result width, 2 .. calyx_sdiv_pkg::MAX_W
// Ports:
//   clk            : rising-edge clock
//   reset_n        : asynchronous active-low reset
//   go             : start/hold request, held high by the caller until done
//   left, right    : signed dividend / divisor, sampled in the start cycle
//   out_quotient   : signed quotient, registered, held until next result
//   out_remainder  : signed remainder, registered, held until next result
//   div_by_zero    : divide-by-zero flag of the last result
//                    (only when STD_SDIV_PIPE_DIV0_FLAG_EN is defined)
//   done           : one-cycle completion pulse
// Latency: go first seen in cycle 0 gives done in cycle width+2.
module std_sdiv_pipe
    import calyx_sdiv_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out_quotient,
    output logic [width-1:0] out_remainder,
`ifdef STD_SDIV_PIPE_DIV0_FLAG_EN
    output logic             div_by_zero,
`endif
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(width);

    sdiv_state_e state_q, state_d;

    logic [width-1:0] dvd_q, dvd_d;      // dividend bits out, quotient bits in
    logic [width:0]   dsr_q, dsr_d;      // divisor magnitude
    logic [width-1:0] rem_q, rem_d;      // partial remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             div0_q, div0_d;
    logic [width-1:0] left_q, left_d;    // raw dividend for the divide-by-zero result
    logic [width-1:0] quot_q, quot_d;
    logic [width-1:0] remo_q, remo_d;
    logic             done_q, done_d;
`ifdef STD_SDIV_PIPE_DIV0_FLAG_EN
    logic             dz_q, dz_d;
`endif

    logic [width-1:0] step_rem;
    logic             step_q;
    mag_t             left_ext;
    mag_t             right_ext;

    assign left_ext  = {{(MAX_W + 1 - width){left[width-1]}}, left};
    assign right_ext = {{(MAX_W + 1 - width){right[width-1]}}, right};

    std_udiv_step #(
        .width (width)
    ) u_step (
        .rem_i (rem_q),
        .msb_i (dvd_q[width-1]),
        .div_i (dsr_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping go in CALC or FIXUP aborts the operation.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (go) state_d = CALC;
            CALC: begin
                if (!go) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: state_d = go ? DONE : IDLE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        div0_d  = div0_q;
        left_d  = left_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        done_d  = 1'b0;
`ifdef STD_SDIV_PIPE_DIV0_FLAG_EN
        dz_d    = dz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    dvd_d   = width'(twos_mag(left_ext));
                    dsr_d   = (width + 1)'(twos_mag(right_ext));
                    rem_d   = '0;
                    cnt_d   = CNT_W'(width - 1);
                    qsign_d = left[width-1] ^ right[width-1];
                    rsign_d = left[width-1];
                    div0_d  = (right == '0);
                    left_d  = left;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[width-2:0], step_q};
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIXUP: begin
                if (go) begin
                    done_d = 1'b1;
                    if (div0_q) begin
                        quot_d = '0;
                        remo_d = left_q;
                    end else begin
                        // MIN / -1 wraps back to MIN through the truncation.
                        quot_d = qsign_q ? (~dvd_q + width'(1)) : dvd_q;
                        remo_d = rsign_q ? (~rem_q + width'(1)) : rem_q;
                    end
`ifdef STD_SDIV_PIPE_DIV0_FLAG_EN
                    dz_d = div0_q;
`endif
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            div0_q  <= 1'b0;
            left_q  <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            div0_q  <= div0_d;
            left_q  <= left_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            done_q  <= done_d;
        end
    end

`ifdef STD_SDIV_PIPE_DIV0_FLAG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end

    assign div_by_zero = dz_q;
`endif

    assign out_quotient  = quot_q;
    assign out_remainder = remo_q;
    assign done          = done_q;

endmodule

// File: tb/tb_std_sdiv_pipe.sv
// Scoreboard bench for std_sdiv_pipe at width=8.
module tb_std_sdiv_pipe;

    localparam int unsigned W = 8;
    localparam int LAT = W + 2;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         go;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         done;
`ifdef STD_SDIV_PIPE_DIV0_FLAG_EN
    logic         div_by_zero;
`endif

    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    std_sdiv_pipe #(
        .width (W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .go            (go),
        .left          (left),
        .right         (right),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
`ifdef STD_SDIV_PIPE_DIV0_FLAG_EN
        .div_by_zero   (div_by_zero),
`endif
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", 32'(out_quotient), 32'(e.q));
                    chk("remainder", 32'(out_remainder), 32'(e.r));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef STD_SDIV_PIPE_DIV0_FLAG_EN
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
`endif
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ed, input int st);
        exp_t e;
        left  = a;
        right = b;
        go    = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.dz  = ed;
        e.cyc = st + LAT;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 4 * LAT);
        if (!done) chk("done_timeout", 32'(done), 32'(1));
    endtask

    // Directed vectors: dividend, divisor, quotient, remainder, div0.
    logic [W-1:0] va [8] = '{8'd7, 8'hF9, 8'd7, 8'h80, 8'h80, 8'd5, 8'd6, 8'd9};
    logic [W-1:0] vb [8] = '{8'd2, 8'd2, 8'hFE, 8'hFF, 8'd3, 8'd0, 8'd3, 8'd4};
    logic [W-1:0] vq [8] = '{8'd3, 8'hFD, 8'hFD, 8'h80, 8'hD6, 8'd0, 8'd2, 8'd2};
    logic [W-1:0] vr [8] = '{8'd1, 8'hFF, 8'd1, 8'd0, 8'hFE, 8'd5, 8'd0, 8'd1};
    logic         vz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int st;
        cyc      = 0;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        go       = 1'b0;
        left     = '0;
        right    = '0;

        repeat (3) @(negedge clk);
        chk("rst_quotient", 32'(out_quotient), 32'(0));
        chk("rst_remainder", 32'(out_remainder), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        reset_n = 1'b1;

        foreach (va[i]) begin
            @(posedge clk);
            #1;
            issue(va[i], vb[i], vq[i], vr[i], vz[i], cyc);
            wait_done();
            go = 1'b0;
        end

        // Abort: start 100/7, drop go in cycle 4, results must hold 9/4.
        @(posedge clk);
        #1;
        st    = cyc;
        left  = 8'd100;
        right = 8'd7;
        go    = 1'b1;
        while (cyc < st + 4) @(posedge clk);
        #1;
        go = 1'b0;
        repeat (3 * LAT) @(negedge clk);
        chk("abort_quotient", 32'(out_quotient), 32'(2));
        chk("abort_remainder", 32'(out_remainder), 32'(1));

        @(posedge clk);
        #1;
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, cyc);
        wait_done();
        go = 1'b0;

        // Asynchronous reset in cycle 5 of an operation.
        @(posedge clk);
        #1;
        st    = cyc;
        left  = 8'd50;
        right = 8'd3;
        go    = 1'b1;
        while (cyc < st + 5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_quotient", 32'(out_quotient), 32'(0));
        chk("async_rst_remainder", 32'(out_remainder), 32'(0));
        chk("async_rst_done", 32'(done), 32'(0));
        go = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back with go held: second start is the IDLE cycle after DONE.
        @(posedge clk);
        #1;
        issue(8'd20, 8'd3, 8'd6, 8'd2, 1'b0, cyc);
        wait_done();
        issue(8'd21, 8'd4, 8'd5, 8'd1, 1'b0, cyc + 1);
        wait_done();
        go = 1'b0;

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/std_sdiv_pipe.md
Name: std_sdiv_pipe

Overview:
- Multi-cycle signed divider. It is the inverse counterpart of the pipelined signed multiplier in the signed-arithmetic primitive library.
- Uses the same go/done latency-insensitive handshake, so compiled Calyx groups can drive it the same way as the multiplier.
- Restoring algorithm on operand magnitudes, one quotient bit per cycle, followed by a sign fix-up.
- Produces both quotient and remainder with C/SystemVerilog truncating semantics.

Parameters:
- width, 32, operand, quotient and remainder width in bits (must be 2 or more).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- go  input  1  start/hold request; held high by the caller until done.
- left  input  width  signed dividend; sampled only in the cycle the operation starts.
- right  input  width  signed divisor; sampled only in the cycle the operation starts.
- out_quotient  output  width  signed quotient, registered.
- out_remainder  output  width  signed remainder, registered.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- While reset_n is low: state=IDLE, out_quotient=0, out_remainder=0, done=0, and all internal registers are 0.
- Reset asserted mid-operation aborts immediately. No done is produced.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE, go=1:
  - Latch |left| into the dividend shift register and |right| into the divisor register.
  - Record the sign of the quotient (sign(left) XOR sign(right)) and the sign of the remainder (sign(left)).
  - Record div0 = (right==0).
  - Clear the partial remainder, load the counter with width-1, go to CALC.
- IDLE, go=0: stay in IDLE.
- CALC, each cycle:
  - Shift the partial remainder left and bring in the dividend MSB.
  - Trial-subtract the divisor using a width+1-bit subtract.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter==0 goes to FIXUP, else decrement.
  - CALC occupies exactly width cycles.
- FIXUP:
  - If div0: out_quotient=0 and out_remainder=left as sampled at start.
  - Else: out_quotient = quotient sign ? -q : q, and out_remainder = remainder sign ? -r : r, both truncated to width.
  - Go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency: if go is first seen high in cycle 0, done is high in cycle width+2. For width=32 this is 34 cycles.
- Back-to-back operation: if go is still high in the IDLE cycle after DONE, a new operation starts with the operands sampled then. There is no combinational go-to-done path.
- go deasserted in CALC or FIXUP: abort to IDLE next cycle. Outputs keep their previous values and no done is produced.
- Outputs hold their last result until the next FIXUP.
- Magnitudes use width+1-bit internal arithmetic so that |MIN| is representable.
- Overflow case MIN / -1: quotient wraps to MIN, remainder 0. No flag is raised.
- Operand changes after the start cycle are ignored.

Optional Feature:
- Macro: STD_SDIV_PIPE_DIV0_FLAG_EN.
- Defined:
  - Adds output port div_by_zero (1 bit).
  - The flag is registered in FIXUP together with the results, so it equals the div0 value of that operation.
  - It holds until the next FIXUP and resets to 0.
- Undefined: the port is absent. The divide-by-zero result values (quotient 0, remainder = left) are unchanged.

Decomposition:
- Package calyx_sdiv_pkg holds:
  - the typedef enum logic [1:0] for the states {IDLE, CALC, FIXUP, DONE};
  - a function for the two's-complement magnitude, parameterised by width through a local width+1 cast.
- Sub-module std_udiv_step: combinational single restoring iteration, parameterised by width.
  - Inputs: partial remainder, dividend MSB, divisor.
  - Outputs: next partial remainder, quotient bit.
  - It is instantiated once inside std_sdiv_pipe.

Test Plan (width=8):
- 7 / 2, go held: done high in cycle 10 only; out_quotient=3, out_remainder=1.
- -7 / 2: out_quotient=0xFD (-3), out_remainder=0xFF (-1). Also 7 / -2: out_quotient=0xFD, out_remainder=1.
- -128 / -1: out_quotient=0x80, out_remainder=0. Also -128 / 3: out_quotient=0xD6 (-42), out_remainder=0xFE (-2).
- 5 / 0: out_quotient=0, out_remainder=5. With the flag macro, div_by_zero=1; a following 6 / 3 gives out_quotient=2 and div_by_zero=0.
- Abort: complete 9 / 4 (out_quotient=2, out_remainder=1), then start 100 / 7 and drop go at cycle 4. Required: no done; out_quotient stays 2 and out_remainder stays 1; a fresh 100 / 7 then gives out_quotient=14, out_remainder=2.
- reset_n pulsed low asynchronously at cycle 5 of an operation: outputs go to 0 immediately and done stays 0. Back-to-back 20 / 3 then 21 / 4 with go held: out_quotient/out_remainder of 6/2 then 5/1, with done pulses 11 cycles apart.
